stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Front-end control stage of the watch controller; sits directly upstream of the
//  Mod10 digit-counter chain. Debounces the two user buttons and runs the
//  IDLE/RUN/PAUSE stopwatch FSM. Drives the counters' start_resume/stop/reset inputs
//  and a divided count-enable tick.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive stable clk cycles needed to accept a button level (>=1)
//  TICK_DIV         10  clk cycles per tick pulse while running (>=2)
// PORTS
//  clk           in   1  single system clock, all state on posedge clk
//  reset         in   1  asynchronous, active-low reset
//  btn_ss        in   1  raw start/stop button, asynchronous, active-high
//  btn_clr       in   1  raw clear button, asynchronous, active-high
//  start_resume  out  1  to counters: 1 while RUN
//  stop          out  1  to counters: 1 while PAUSE
//  cnt_reset     out  1  to counters (synchronous active-high reset): one-cycle clear pulse
//  tick          out  1  one-cycle count enable, every TICK_DIV cycles in RUN
//  state         out  2  current FSM state (debug/display)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; start_resume=0, stop=0, cnt_reset=0, tick=0.
//   Prescaler=0, debounce counters=0, stable levels=0, sync flops=0.
//  Debounce, per button:
//   - 2-FF synchroniser.
//   - Counter increments while the synced level != the stable level, and clears
//     when they are equal.
//   - When the counter reaches DEBOUNCE_CYCLES, the stable level takes the synced
//     value.
//   - A registered press pulse fires on each 0->1 transition of the stable level.
//   - Glitches shorter than DEBOUNCE_CYCLES never produce a pulse.
//   - Releases produce no pulse.
//  FSM (press pulse acts on the next posedge), encodings ST_IDLE=00, ST_RUN=01, ST_PAUSE=10:
//   - IDLE : ss -> RUN. clr -> stay IDLE and emit cnt_reset.
//   - RUN  : ss -> PAUSE. clr is ignored.
//   - PAUSE: ss -> RUN. clr -> IDLE and emit cnt_reset.
//   - Illegal 11 -> IDLE with cnt_reset.
//   - Simultaneous ss+clr: in RUN, ss wins (-> PAUSE, clr dropped). In IDLE/PAUSE, clr
//     wins (-> IDLE, ss dropped).
//  Outputs (all registered, decoded from next-state):
//   - start_resume = (state==RUN).
//   - stop = (state==PAUSE).
//   - cnt_reset = 1 for exactly one cycle, on the cycle the clear transition lands.
//  Latency: raw button rise (held stable) -> start_resume change = DEBOUNCE_CYCLES+4 clk.
//  Prescaler:
//   - Counts 0..TICK_DIV-1 only in RUN, then wraps to 0.
//   - tick=1 in the cycle after the count equals TICK_DIV-1.
//   - First tick occurs TICK_DIV cycles after entering RUN from IDLE.
//   - Holds its value in PAUSE, so a resume continues the partial period.
//   - Cleared to 0 with cnt_reset.
//   - tick is never 1 outside RUN.
//  Widths: prescaler $clog2(TICK_DIV); debounce counter $clog2(DEBOUNCE_CYCLES+1).
//   Unsigned; no overflow past the terminal count.
//  Mid-operation reset: asserting reset at any time forces the reset values immediately.
//   After release, the block is in IDLE; buttons already held at release must first be
//   debounced to stable 1 before they produce a press pulse.
// STRUCTURE
//  Shared header stopwatch_defs.vh: ST_IDLE/ST_RUN/ST_PAUSE encodings and the state width.
//  The counters and display logic also use this header.
//  One sub-module, btn_debounce (param DEBOUNCE_CYCLES; clk, reset, raw -> level, press),
//  instantiated twice. FSM and prescaler live in stopwatch_ctrl.
// TESTING (DEBOUNCE_CYCLES=4, TICK_DIV=10)
//  1. Reset, hold btn_ss=1 for 20 cycles
//     -> start_resume rises exactly 8 cycles after btn_ss rises; state=01;
//        first tick 10 cycles after that, then every 10 cycles.
//  2. 3-cycle btn_ss glitch in IDLE -> no press pulse; state stays 00; start_resume stays 0.
//  3. RUN, press ss at prescaler=6, later press ss again
//     -> PAUSE (stop=1, start_resume=0, no tick); on resume, next tick after 3 cycles.
//  4. PAUSE, press ss and clr simultaneously -> IDLE; cnt_reset high exactly 1 cycle; prescaler=0.
//     In RUN, press both -> PAUSE; no cnt_reset.
//  5. RUN, press clr alone -> no state change; cnt_reset stays 0; tick cadence unchanged.
//  6. Assert reset mid-RUN while btn_ss is held -> outputs 0, state=00 asynchronously;
//     after release, exactly one press pulse after 8 cycles -> RUN.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared stopwatch definitions: FSM state encodings, state width and a counter-width helper.
// Also used by the digit counters and display logic.
package stopwatch_ctrl_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle    = 2'b00,
    StRun     = 2'b01,
    StPause   = 2'b10,
    StIllegal = 2'b11
  } sw_state_e;

  // Width for a counter that must hold values up to n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: 2-FF synchroniser, stability counter and a registered rising-edge
// press pulse. Releases never pulse.
module btn_debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic            prev_q, press_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The counter reaching its terminal value on this edge commits the new level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CntMax) stable_d = sync2_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      prev_q   <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      prev_q   <= stable_q;
      press_q  <= stable_q & ~prev_q;
    end
  end

  assign level = stable_q;
  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: debounced start/stop and clear buttons, IDLE/RUN/PAUSE FSM and
// a count-enable prescaler for the downstream digit counters.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TICK_DIV        = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_ss,
  input  logic              btn_clr,
  output logic              start_resume,
  output logic              stop,
  output logic              cnt_reset,
  output logic              tick,
  output logic [StateW-1:0] state
);

  localparam int unsigned PreW = cnt_width(TICK_DIV);
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  logic ss_press, clr_press;
  logic unused_ss_level, unused_clr_level;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_ss (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_ss),
    .level(unused_ss_level),
    .press(ss_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_clr (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_clr),
    .level(unused_clr_level),
    .press(clr_press)
  );

  sw_state_e       state_q, state_d;
  logic            clr_d, tick_d;
  logic [PreW-1:0] presc_q, presc_d;
  logic            start_resume_q, stop_q, cnt_reset_q, tick_q;

  // In RUN start/stop has priority; elsewhere clear has priority.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (clr_press)     clr_d = 1'b1;
        else if (ss_press) state_d = StRun;
      end
      StRun: begin
        if (ss_press) state_d = StPause;
      end
      StPause: begin
        if (clr_press) begin
          state_d = StIdle;
          clr_d   = 1'b1;
        end else if (ss_press) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StIdle;
        clr_d   = 1'b1;
      end
    endcase
  end

  // Prescaler advances on every cycle spent in RUN; a tick is suppressed if RUN is leaving.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (clr_d) begin
      presc_d = '0;
    end else if (state_q == StRun) begin
      if (presc_q == PreMax) begin
        presc_d = '0;
        tick_d  = (state_d == StRun);
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      presc_q        <= '0;
      start_resume_q <= 1'b0;
      stop_q         <= 1'b0;
      cnt_reset_q    <= 1'b0;
      tick_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      start_resume_q <= (state_d == StRun);
      stop_q         <= (state_d == StPause);
      cnt_reset_q    <= clr_d;
      tick_q         <= tick_d;
    end
  end

  assign start_resume = start_resume_q;
  assign stop         = stop_q;
  assign cnt_reset    = cnt_reset_q;
  assign tick         = tick_q;
  assign state        = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=10.
module tb_stopwatch_ctrl;

  localparam int unsigned DC = 4;
  localparam int unsigned TD = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_clr = 1'b0;
  logic       start_resume, stop, cnt_reset, tick;
  logic [1:0] state;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .TICK_DIV       (TD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_ss      (btn_ss),
    .btn_clr     (btn_clr),
    .start_resume(start_resume),
    .stop        (stop),
    .cnt_reset   (cnt_reset),
    .tick        (tick),
    .state       (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int bad_tick = 0;
  int tick_cnt = 0;
  int crst_cnt = 0;

  typedef struct {
    logic       ss;
    logic       clr;
    logic [1:0] exp_state;
    logic       exp_sr;
    logic       exp_stop;
    int         exp_crst;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (tick && state != 2'b01) bad_tick++;
    if (tick) tick_cnt++;
    if (cnt_reset) crst_cnt++;
  endtask

  // which: 0=start_resume, 1=stop, 2=tick. n = cycles until seen, -1 on timeout.
  task automatic wait_sig(input int which, output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if ((which == 0 && start_resume) || (which == 1 && stop) || (which == 2 && tick)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic apply_vec(input int idx);
    int c0;
    c0      = crst_cnt;
    btn_ss  = vecs[idx].ss;
    btn_clr = vecs[idx].clr;
    repeat (16) step();
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    repeat (10) step();
    chk($sformatf("vec%0d_state", idx), int'(state), int'(vecs[idx].exp_state));
    chk($sformatf("vec%0d_start_resume", idx), int'(start_resume), int'(vecs[idx].exp_sr));
    chk($sformatf("vec%0d_stop", idx), int'(stop), int'(vecs[idx].exp_stop));
    chk($sformatf("vec%0d_cnt_reset_cycles", idx), crst_cnt - c0, vecs[idx].exp_crst);
  endtask

  initial begin
    int n, c0, t0;
    logic sr_seen;

    vecs[0] = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 0};
    vecs[2] = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1};
    vecs[3] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1};
    vecs[4] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 0};
    vecs[5] = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 0};
    vecs[6] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1};
    vecs[7] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 0};

    // Reset values and start latency.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_start_resume", int'(start_resume), 0);
    chk("rst_stop", int'(stop), 0);
    chk("rst_cnt_reset", int'(cnt_reset), 0);
    chk("rst_tick", int'(tick), 0);
    reset = 1'b1;
    repeat (2) step();
    btn_ss = 1'b1;
    wait_sig(0, n);
    chk("start_latency", n, 8);
    chk("start_state", int'(state), 1);
    wait_sig(2, n);
    chk("first_tick", n, 10);
    wait_sig(2, n);
    chk("tick_period", n, 10);
    btn_ss = 1'b0;
    repeat (12) step();
    chk("release_no_pulse_state", int'(state), 1);

    // Glitch rejection in IDLE, then the shortest accepted pulse.
    reset = 1'b0;
    #2;
    reset = 1'b1;
    step();
    btn_ss = 1'b1;
    repeat (3) step();
    btn_ss  = 1'b0;
    sr_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      sr_seen |= start_resume;
    end
    chk("glitch_state", int'(state), 0);
    chk("glitch_start_resume", int'(sr_seen), 0);
    btn_ss = 1'b1;
    repeat (4) step();
    btn_ss = 1'b0;
    repeat (12) step();
    chk("min_pulse_state", int'(state), 1);

    // Pause with prescaler at 6, resume finishes the partial period.
    wait_sig(2, n);
    chk("pause_sync_tick_found", int'(n > 0), 1);
    repeat (9) step();
    t0     = tick_cnt;
    btn_ss = 1'b1;
    wait_sig(1, n);
    chk("pause_latency", n, 8);
    chk("ticks_before_pause", tick_cnt - t0, 1);
    btn_ss = 1'b0;
    t0     = tick_cnt;
    repeat (15) step();
    chk("pause_state", int'(state), 2);
    chk("pause_start_resume", int'(start_resume), 0);
    chk("pause_stop", int'(stop), 1);
    chk("pause_no_tick", tick_cnt - t0, 0);
    btn_ss = 1'b1;
    wait_sig(0, n);
    chk("resume_latency", n, 8);
    wait_sig(2, n);
    chk("resume_tick", n, 3);
    btn_ss = 1'b0;
    repeat (10) step();

    // Clear while running is ignored and does not disturb the tick cadence.
    wait_sig(2, n);
    c0      = crst_cnt;
    btn_clr = 1'b1;
    wait_sig(2, n);
    chk("run_clr_tick1", n, 10);
    wait_sig(2, n);
    chk("run_clr_tick2", n, 10);
    btn_clr = 1'b0;
    repeat (5) step();
    chk("run_clr_no_cnt_reset", crst_cnt - c0, 0);
    chk("run_clr_state", int'(state), 1);

    for (int i = 0; i < 8; i++) apply_vec(i);

    // Clear from PAUSE with a non-zero prescaler must restart the period from zero.
    btn_ss = 1'b1;
    wait_sig(0, n);
    btn_ss = 1'b0;
    wait_sig(2, n);
    repeat (3) step();
    btn_ss = 1'b1;
    wait_sig(1, n);
    chk("presc_pause_reached", n, 8);
    btn_ss = 1'b0;
    repeat (10) step();
    c0      = crst_cnt;
    btn_ss  = 1'b1;
    btn_clr = 1'b1;
    repeat (12) step();
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    repeat (5) step();
    chk("presc_clr_state", int'(state), 0);
    chk("presc_clr_cnt_reset", crst_cnt - c0, 1);
    btn_ss = 1'b1;
    wait_sig(0, n);
    wait_sig(2, n);
    chk("presc_cleared_tick", n, 10);

    // Asynchronous reset mid-RUN with the button held.
    repeat (3) step();
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_start_resume", int'(start_resume), 0);
    chk("async_rst_stop", int'(stop), 0);
    chk("async_rst_tick", int'(tick), 0);
    repeat (2) step();
    reset = 1'b1;
    wait_sig(0, n);
    chk("post_rst_latency", n, 8);
    repeat (20) step();
    chk("post_rst_single_pulse", int'(state), 1);
    btn_ss = 1'b0;
    repeat (5) step();

    chk("tick_outside_run", bad_tick, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
